// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock-enable divider.
// Each channel divides clk by a runtime-loadable integer N and produces a
// near-50%-duty registered output plus a one-cycle tick on every rising
// edge of that output. New divisors wait in a shadow register and are only
// applied at a period boundary, a sync edge, or straight away when the
// channel is off (N=0), so the outputs never glitch.
//
// Handshake: div_ld[i] is a plain write strobe with no back-pressure; every
// non-reset edge that sees div_ld[i]=1 captures the div_val slice into the
// shadow and raises pend[i]. pend[i] falls on the edge that moves the shadow
// into the active divisor. tick and div_out are registered clock enables
// and fabric signals, not clocks.
module clk_div_prog #(
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sync,
  input  logic [NUM_CH-1:0]       div_ld,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  output logic [NUM_CH-1:0]       div_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       pend
);

  localparam logic [DIV_W-1:0] DEF_N  = DEF_DIV[DIV_W-1:0];
  localparam logic [DIV_W-1:0] ONE    = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W:0]   ONE_X  = {{DIV_W{1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] ZERO   = '0;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] n_q;      // active divisor
    logic [DIV_W-1:0] s_q;      // shadow divisor
    logic [DIV_W-1:0] cnt_q;    // position inside the current period
    logic             pend_q;
    logic             out_q;
    logic             tick_q;
    logic [DIV_W:0]   half;     // ceil(N/2), one bit wider so N=2^DIV_W-1 cannot wrap
    logic             last;     // counter sits on the final cycle of the period
    logic             high;     // output level for the current counter value

    // Derived per-channel values used by the counting branch.
    always_comb begin
      half = ({1'b0, n_q} + ONE_X) >> 1;
      last = (cnt_q == (n_q - ONE));
      high = ({1'b0, cnt_q} < half);
    end

    // Channel state: reset, then sync, then enabled counting, then hold;
    // a divisor load is layered on top of whichever of those happened.
    always_ff @(posedge clk) begin
      if (!rst) begin
        n_q    <= DEF_N;
        s_q    <= DEF_N;
        cnt_q  <= ZERO;
        pend_q <= 1'b0;
        out_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        if (sync) begin
          cnt_q  <= ZERO;
          out_q  <= 1'b0;
          tick_q <= 1'b0;
          if (pend_q) begin
            n_q    <= s_q;
            pend_q <= 1'b0;
          end
        end else if (en) begin
          if (n_q == ZERO) begin
            // Channel off: outputs parked low, a pending divisor applies now.
            cnt_q  <= ZERO;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
            if (pend_q) begin
              n_q    <= s_q;
              pend_q <= 1'b0;
            end
          end else begin
            out_q  <= high;
            tick_q <= (cnt_q == ZERO);
            if (last) begin
              cnt_q <= ZERO;
              if (pend_q) begin
                n_q    <= s_q;
                pend_q <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + ONE;
            end
          end
        end else begin
          tick_q <= 1'b0;
        end

        // A load on the same edge as an apply refills the shadow and keeps
        // pend high, so the new value waits for the following boundary.
        if (div_ld[i]) begin
          s_q    <= div_val[i*DIV_W +: DIV_W];
          pend_q <= 1'b1;
        end
      end
    end

    assign div_out[i] = out_q;
    assign tick[i]    = tick_q;
    assign pend[i]    = pend_q;
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Testbench for clk_div_prog: a behavioural channel model predicts
// {pend, tick, div_out} for every edge, pushes it on a queue, and the
// sampled DUT outputs are popped and compared; directed pattern checks
// cover the named scenarios on top of that.
module tb_clk_div_prog;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int W   = 3 * NCH;

  logic              clk;
  logic              rst;
  logic              en;
  logic              sync;
  logic [NCH-1:0]    div_ld;
  logic [NCH*DW-1:0] div_val;
  logic [NCH-1:0]    div_out;
  logic [NCH-1:0]    tick;
  logic [NCH-1:0]    pend;

  clk_div_prog #(.NUM_CH(NCH), .DIV_W(DW), .DEF_DIV(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sync    (sync),
    .div_ld  (div_ld),
    .div_val (div_val),
    .div_out (div_out),
    .tick    (tick),
    .pend    (pend)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  int m_n[NCH];
  int m_s[NCH];
  int m_cnt[NCH];
  bit m_pend[NCH];
  bit m_out[NCH];
  bit m_tick[NCH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference channel behaviour for one rising edge using the current inputs.
  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      if (!rst) begin
        m_n[c] = 2; m_s[c] = 2; m_cnt[c] = 0;
        m_pend[c] = 0; m_out[c] = 0; m_tick[c] = 0;
      end else begin
        bit apply;
        apply = 0;
        if (sync) begin
          m_cnt[c] = 0; m_out[c] = 0; m_tick[c] = 0;
          apply = m_pend[c];
        end else if (en) begin
          if (m_n[c] == 0) begin
            m_cnt[c] = 0; m_out[c] = 0; m_tick[c] = 0;
            apply = m_pend[c];
          end else begin
            m_out[c]  = (m_cnt[c] < (m_n[c] + 1) / 2);
            m_tick[c] = (m_cnt[c] == 0);
            if (m_cnt[c] == m_n[c] - 1) begin
              m_cnt[c] = 0;
              apply = m_pend[c];
            end else begin
              m_cnt[c] = m_cnt[c] + 1;
            end
          end
        end else begin
          m_tick[c] = 0;
        end
        if (apply) begin
          m_n[c] = m_s[c];
          m_pend[c] = 0;
        end
        if (div_ld[c]) begin
          m_s[c] = int'(div_val[c*DW +: DW]);
          m_pend[c] = 1;
        end
      end
    end
  endtask

  function automatic logic [W-1:0] model_vec();
    logic [W-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) begin
      v[2*NCH + c] = m_pend[c];
      v[NCH + c]   = m_tick[c];
      v[c]         = m_out[c];
    end
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [W-1:0] e;
    model_edge();
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("sb", {pend, tick, div_out}, e);
    div_ld = '0;
    sync   = 1'b0;
  endtask

  task automatic load(input int ch, input int v);
    div_ld[ch] = 1'b1;
    div_val[ch*DW +: DW] = v[DW-1:0];
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0]  pat_odd;
    logic [12:0] pat_chg;
    int hi, tk, ecnt;
    bit seen;

    rst = 1'b0; en = 1'b0; sync = 1'b0; div_ld = '0; div_val = '0;

    // reset defaults
    repeat (3) begin
      step();
      check("rst_out", {pend, tick, div_out}, 0);
    end
    rst = 1'b1; en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("def_out", div_out[0], (k % 2 == 0));
      check("def_tick", tick[0], (k % 2 == 0));
    end

    // odd divisor on ch0, loaded while disabled and applied by sync
    en = 1'b0;
    load(0, 5); step();
    sync = 1'b1; step();
    check("odd_pend", pend[0], 0);
    en = 1'b1;
    pat_odd = 10'b1110011100;
    for (int k = 0; k < 10; k++) begin
      step();
      check("odd_out", div_out[0], pat_odd[9-k]);
      check("odd_tick", tick[0], (k % 5 == 0));
    end

    // glitch-free change on ch1: 6 -> 3 loaded at cnt=2
    load(1, 6); step();
    sync = 1'b1; step();
    pat_chg = 13'b1110001101101;
    for (int k = 0; k < 13; k++) begin
      if (k == 2) load(1, 3);
      step();
      check("chg_out", div_out[1], pat_chg[12-k]);
      check("chg_tick", tick[1], (k == 0 || k == 6 || k == 9 || k == 12));
      check("chg_pend", pend[1], (k >= 2 && k <= 4));
    end

    // same-edge load at wrap on ch2: N=4, S=8 pending, load 2 on the wrap
    load(2, 4); step();
    sync = 1'b1; step();
    for (int k = 0; k < 15; k++) begin
      if (k == 0) load(2, 8);
      if (k == 3) load(2, 2);
      step();
      check("same_tick", tick[2], (k == 0 || k == 4 || k == 12 || k == 14));
      check("same_pend", pend[2], (k <= 10));
    end

    // N=0 parks ch3 low
    load(3, 0); step();
    sync = 1'b1; step();
    for (int k = 0; k < 5; k++) begin
      step();
      check("n0_out", div_out[3], 0);
      check("n0_tick", tick[3], 0);
    end
    // N=1 applies on the next enabled edge while the channel is off
    load(3, 1); step();
    check("n1_pend_set", pend[3], 1);
    step();
    check("n1_pend_clr", pend[3], 0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("n1_out", div_out[3], 1);
      check("n1_tick", tick[3], 1);
    end

    // N=255 on ch0: 128 high, 127 low, one tick per period
    load(0, 255); step();
    sync = 1'b1; step();
    hi = 0; tk = 0;
    for (int k = 0; k < 255; k++) begin
      step();
      hi += int'(div_out[0]);
      tk += int'(tick[0]);
    end
    check("n255_hi", hi, 128);
    check("n255_tick", tk, 1);
    step();
    check("n255_wrap", tick[0], 1);

    // random enable: ch3 period must be 7 enabled edges
    load(0, 2); load(1, 3); load(2, 4); load(3, 7); step();
    sync = 1'b1; step();
    ecnt = 0; seen = 0;
    for (int k = 0; k < 200; k++) begin
      en = 1'($urandom_range(0, 1));
      step();
      if (en) begin
        ecnt++;
        if (tick[3]) begin
          if (seen) check("en_period", ecnt, 7);
          seen = 1;
          ecnt = 0;
        end
      end
    end

    // sync mid-period realigns every channel
    en = 1'b1;
    repeat (3) step();
    sync = 1'b1; step();
    check("sync_low", {tick, div_out}, 0);
    step();
    check("sync_rise", div_out, 4'hf);
    check("sync_tick", tick, 4'hf);

    // reset mid-period discards the pending load
    step();
    load(1, 9); step();
    rst = 1'b0; step();
    check("rst_mid", {pend, tick, div_out}, 0);
    rst = 1'b1;
    step();
    check("rst_def_a", div_out[1], 1);
    step();
    check("rst_def_b", div_out[1], 0);
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Multi-channel programmable clock-enable divider, the parametrised successor to the fixed power-of-two divider. Each of NUM_CH channels divides `clk` by a runtime-loadable integer of DIV_W bits, producing a near-50%-duty divided output and a one-cycle tick at each output rising edge. Ratio changes are shadowed and applied only at a period boundary, so outputs never glitch. A common `sync` input realigns all channel phases. The block sits between the system clock and slow peripherals such as LED scanners, debouncers and UART baud generators; outputs are fabric signals and clock enables, not clock-tree drivers.

## Interface
- NUM_CH, 4, number of independent channels (1..16)
- DIV_W, 8, divisor width in bits (2..16)
- DEF_DIV, 2, divisor loaded into every channel's active and shadow registers at reset (0..2^DIV_W-1)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- en  in  1  global count enable; 0 freezes all channels
- sync  in  1  phase realign of all channels (single-cycle pulse or level)
- div_ld  in  NUM_CH  per-channel load strobe for the divisor
- div_val  in  NUM_CH*DIV_W  divisor values, channel i at bits [i*DIV_W +: DIV_W]
- div_out  out  NUM_CH  divided outputs, registered
- tick  out  NUM_CH  one-cycle pulse coincident with each div_out rising edge, registered
- pend  out  NUM_CH  1 while a loaded divisor waits in the shadow register

## Operation
- Per-channel state: active divisor N (DIV_W bits), shadow divisor S, pend flag, counter cnt (DIV_W bits), div_out and tick registers. H = ceil(N/2), computed as (N+1)>>1 in DIV_W+1 bits to avoid overflow at N = 2^DIV_W-1.
- Priority at each edge: rst low, then sync, then en, then hold.
- Reset (rst=0): cnt=0, div_out=0, tick=0, pend=0, N=S=DEF_DIV.
- Load: div_ld[i]=1 writes div_val slice to S[i] and sets pend[i] on any non-reset edge, independent of en and sync. A repeat load before apply overwrites S; last value wins.
- Counting (en=1, sync=0, N>=1): div_out<=(cnt<H); tick<=(cnt==0); cnt<=(cnt==N-1)?0:cnt+1.
- Apply: on a counting edge with cnt==N-1 and pend=1, N<=S, pend<=0, cnt<=0. S is the value registered before this edge; a div_ld on the same edge updates S and keeps pend=1, so it applies at the next wrap.
- N=0 means channel off: div_out<=0, tick<=0, cnt held 0. If pend=1, apply happens on the next edge with en=1 regardless of cnt.
- N=1: div_out constant 1, tick every enabled cycle.
- Odd N: div_out high for H cycles and low for N-H cycles.
- en=0: cnt, div_out, N and pend hold; tick<=0; no apply.
- sync=1: for every channel, cnt<=0, div_out<=0, tick<=0. If pend=1, N<=S and pend<=0. This happens regardless of en. The next counting edge raises all enabled, non-zero channels together.

## Timing
- Outputs are registered with no combinational path from inputs to outputs.
- First enabled edge after reset or sync: div_out and tick go high, so they are visible one cycle after the edge.
- Period is exactly N enabled cycles. Disabled cycles stretch the current phase and do not reset it.
- Load-to-apply latency: at most N enabled cycles after the load edge. Zero extra latency if the channel is off, or the load precedes a wrap edge by at least one cycle.
- pend rises the cycle after div_ld and falls the cycle after the apply edge.
- Reset asserted mid-period: all outputs are low the cycle after, and any pending load is discarded.

## Test plan
- Reset defaults: DEF_DIV=2, hold rst=0 for 3 cycles, then rst=1, en=1. Expect div_out and tick low during reset. Afterwards div_out toggles every cycle (1,0,1,0) and tick goes high on each high cycle.
- Odd divisor: load 5 into ch0 while en=0, then pulse sync and set en=1. Expect the div_out pattern 1,1,1,0,0 repeating, tick once per 5 cycles, and pend cleared by the sync.
- Glitch-free change: ch1 running at N=6; load 3 at cnt=2. Expect the current period to complete at 6 cycles, pend=1 until the wrap, then period 3 with pattern 1,1,0.
- Same-edge load at wrap: ch2 at N=4 with pend=1 and S=8. Load 2 on the wrap edge. Expect N=8 for one period with pend still 1, then N=2.
- Boundaries: load N=0 and expect div_out and tick held 0. Load N=1 and expect div_out=1 constantly and tick every cycle. Load N=255 (DIV_W=8) and expect 128 high cycles, 127 low cycles, and no overflow.
- Enable and sync: toggle en randomly and check the period equals N enabled cycles. Assert sync mid-period on 4 channels with N=2,3,4,7 and expect all div_out rising on the same cycle afterwards. Assert rst=0 mid-period and expect all outputs 0 on the next cycle.
